gb_wavetable_channel: RTL and testbench

Parametrised wavetable playback channel for the APU, successor to the fixed 32×4-bit custom wave channel. It owns its wave RAM internally, behind a CPU access port with play-time lockout. It also contains the period divider, length counter and DAC gating. Sample width, table depth, period width, divider prescale and length width are all generic. It sits between the APU register file (frequency/volume/length/trigger) and the channel mixer.

---
 rtl/gb_wavetable_channel.sv | 126 ++++++++++++
 tb/tb_gb_wavetable_channel.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gb_wavetable_channel.sv
// Wavetable playback channel: internal wave RAM with CPU port and play-time lockout,
// period divider, length counter and DAC gating.
module gb_wavetable_channel #(
  parameter int unsigned SAMPLE_BITS = 4,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned PERIOD_BITS = 11,
  parameter int unsigned DIV_SHIFT   = 1,
  parameter int unsigned LENGTH_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_length_ctr,
  input  logic                   start,
  input  logic                   dac_on,
  input  logic                   length_en,
  input  logic                   length_load,
  input  logic [LENGTH_BITS-1:0] length,
  input  logic [1:0]             volume,
  input  logic [PERIOD_BITS-1:0] frequency,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [ADDR_BITS-1:0]   cpu_addr,
  input  logic [SAMPLE_BITS-1:0] cpu_wdata,
  output logic [SAMPLE_BITS-1:0] cpu_rdata,
  output logic                   cpu_ack,
  output logic [SAMPLE_BITS-1:0] level,
  output logic                   active,
  output logic [ADDR_BITS-1:0]   position
);

  localparam int unsigned DIV_W = PERIOD_BITS + DIV_SHIFT;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [LENGTH_BITS:0] LEN_FULL = {1'b1, {LENGTH_BITS{1'b0}}};

  logic [SAMPLE_BITS-1:0] mem [DEPTH];

  logic                   start_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic                   fetch_q, fetch_d;
  logic [SAMPLE_BITS-1:0] buf_q;
  logic [LENGTH_BITS:0]   len_q, len_d, len_dec;
  logic                   active_q, active_d;
  logic                   ack_q;
  logic [SAMPLE_BITS-1:0] rdata_q;
  logic                   trig, expire;
  logic [DIV_W-1:0]       reload_val;

  always_comb begin
    trig       = start & ~start_q;
    reload_val = DIV_W'(frequency) << DIV_SHIFT;
    len_dec    = len_q - 1'b1;
    div_d      = div_q;
    ptr_d      = ptr_q;
    fetch_d    = 1'b0;
    len_d      = len_q;
    expire     = 1'b0;
    active_d   = active_q;

    if (trig) begin
      div_d = reload_val;
      ptr_d = '0;
    end else if (active_q) begin
      if (div_q == '1) begin
        div_d   = reload_val;
        ptr_d   = ptr_q + 1'b1;
        fetch_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Load beats both trigger reload and tick; a tick coincident with a trigger is ignored.
    if (length_load) begin
      len_d = LEN_FULL - {1'b0, length};
    end else if (trig) begin
      if (len_q == '0) len_d = LEN_FULL;
    end else if (clk_length_ctr && length_en && (len_q != '0)) begin
      len_d  = len_dec;
      expire = (len_dec == '0);
    end

    if (trig)        active_d = dac_on;
    else if (expire) active_d = 1'b0;
    if (!dac_on)     active_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (cpu_we && !active_q) mem[cpu_addr] <= cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      div_q    <= '0;
      ptr_q    <= '0;
      fetch_q  <= 1'b0;
      buf_q    <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      start_q  <= start;
      div_q    <= div_d;
      ptr_q    <= ptr_d;
      fetch_q  <= fetch_d;
      len_q    <= len_d;
      active_q <= active_d;
      ack_q    <= cpu_we | cpu_re;
      if (fetch_q) buf_q <= mem[ptr_q];
      if (cpu_re)  rdata_q <= active_q ? buf_q : mem[cpu_addr];
    end
  end

  always_comb begin
    level = '0;
    if (active_q && (volume != 2'b00)) level = buf_q >> (volume - 2'd1);
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign active    = active_q;
  assign position  = ptr_q;

endmodule

// File: tb/tb_gb_wavetable_channel.sv
// Directed bench for gb_wavetable_channel with default parameters.
module tb_gb_wavetable_channel;

  logic       clk = 1'b0;
  logic       reset, clk_length_ctr, start, dac_on, length_en, length_load;
  logic [7:0] length;
  logic [1:0] volume;
  logic [10:0] frequency;
  logic       cpu_we, cpu_re;
  logic [4:0] cpu_addr;
  logic [3:0] cpu_wdata, cpu_rdata, level;
  logic       cpu_ack, active;
  logic [4:0] position;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  gb_wavetable_channel #(
    .SAMPLE_BITS(4), .ADDR_BITS(5), .PERIOD_BITS(11), .DIV_SHIFT(1), .LENGTH_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .clk_length_ctr(clk_length_ctr), .start(start),
    .dac_on(dac_on), .length_en(length_en), .length_load(length_load),
    .length(length), .volume(volume), .frequency(frequency),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .level(level), .active(active),
    .position(position)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clk_length_ctr = 1'b0; start = 1'b0; dac_on = 1'b0;
    length_en = 1'b0; length_load = 1'b0; length = '0; volume = 2'b01;
    frequency = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_active", active, 0);
    chk("rst_position", position, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();

    // CPU round-trip while inactive
    for (int i = 0; i < 32; i++) begin
      cpu_we = 1'b1; cpu_addr = 5'(i); cpu_wdata = 4'(i);
      step();
      cpu_we = 1'b0;
      chk("wr_ack", cpu_ack, 1);
    end
    for (int i = 0; i < 32; i++) begin
      cpu_re = 1'b1; cpu_addr = 5'(i);
      step();
      cpu_re = 1'b0;
      chk("rd_ack", cpu_ack, 1);
      chk("rd_data", cpu_rdata, i % 16);
      step();
      chk("ack_pulse", cpu_ack, 0);
    end

    // Playback cadence: period (2048-2040)*2 = 16 cycles
    frequency = 11'd2040; dac_on = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("trig_active", active, 1);
    chk("trig_position", position, 0);
    chk("trig_level_old", level, 0);
    repeat (15) step();
    chk("pos_hold", position, 0);
    step();
    chk("pos_adv1", position, 1);
    chk("level_lag", level, 0);
    step();
    chk("level_adv1", level, 1);
    for (int k = 2; k <= 33; k++) begin
      repeat (15) step();
      chk("pos_adv", position, k % 32);
      chk("level_prev", level, (k - 1) % 16);
      step();
      chk("level_adv", level, k % 16);
    end

    // Stop, then place 0xB at index 1 and play it slowly (period 4096)
    dac_on = 1'b0;
    step();
    chk("dac_off", active, 0);
    cpu_we = 1'b1; cpu_addr = 5'd1; cpu_wdata = 4'hB;
    step();
    cpu_we = 1'b0;
    frequency = 11'd0; dac_on = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("slow_active", active, 1);
    repeat (4095) step();
    chk("slow_hold", position, 0);
    step();
    chk("slow_adv", position, 1);
    step();
    chk("vol01", level, 4'hB);
    volume = 2'b10; #1;
    chk("vol10", level, 4'h5);
    volume = 2'b11; #1;
    chk("vol11", level, 4'h2);
    volume = 2'b00; #1;
    chk("vol00", level, 4'h0);
    volume = 2'b01;

    // Lockout while active
    cpu_we = 1'b1; cpu_addr = 5'd1; cpu_wdata = 4'hF;
    step();
    cpu_we = 1'b0;
    chk("lock_wr_ack", cpu_ack, 1);
    cpu_re = 1'b1; cpu_addr = 5'd5;
    step();
    cpu_re = 1'b0;
    chk("lock_rd_ack", cpu_ack, 1);
    chk("lock_rd_data", cpu_rdata, 4'hB);

    // Length expiry: 256-254 = 2 ticks
    length = 8'd254; length_load = 1'b1;
    step();
    length_load = 1'b0; length_en = 1'b1;
    clk_length_ctr = 1'b1;
    step();
    clk_length_ctr = 1'b0;
    chk("len_tick1", active, 1);
    clk_length_ctr = 1'b1;
    step();
    clk_length_ctr = 1'b0;
    chk("len_expire", active, 0);
    chk("len_level", level, 0);
    clk_length_ctr = 1'b1;
    step();
    clk_length_ctr = 1'b0;
    chk("len_tick3", active, 0);
    repeat (3) step();
    chk("pos_frozen", position, 1);
    cpu_re = 1'b1; cpu_addr = 5'd1;
    step();
    cpu_re = 1'b0;
    chk("ram_unchanged", cpu_rdata, 4'hB);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("retrig_active", active, 1);
    chk("retrig_pos", position, 0);

    // Trigger with DAC off
    dac_on = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("trig_dac_off", active, 0);

    // Trigger coincident with tick at counter = 1
    dac_on = 1'b1; length = 8'd255; length_load = 1'b1;
    step();
    length_load = 1'b0;
    start = 1'b1; clk_length_ctr = 1'b1;
    step();
    start = 1'b0; clk_length_ctr = 1'b0;
    chk("trig_tick_active", active, 1);
    clk_length_ctr = 1'b1;
    step();
    clk_length_ctr = 1'b0;
    chk("counter_was_one", active, 0);

    // Reset mid-play
    frequency = 11'd2040; start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    chk("midplay_pos", position, 1);
    reset = 1'b1; cpu_re = 1'b1; cpu_addr = 5'd2;
    step();
    cpu_re = 1'b0;
    chk("rst2_level", level, 0);
    chk("rst2_active", active, 0);
    chk("rst2_position", position, 0);
    chk("rst2_ack", cpu_ack, 0);
    chk("rst2_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
